// File: rtl/ladybird_bus_arbiter.sv
// Two-master (D_BUS load/store, I_BUS fetch) round-robin arbiter onto one shared memory port.
// One outstanding transaction; requests are region-tagged; fetches from device space are refused locally.
package ladybird_pkg;
  localparam int XLEN = 32;

  typedef enum logic {D_BUS = 1'b0, I_BUS = 1'b1} core_bus_t;

  typedef enum logic [2:0] {
    ACC_IRAM = 3'd0,
    ACC_BRAM = 3'd1,
    ACC_DRAM = 3'd2,
    ACC_UART = 3'd3,
    ACC_GPIO = 3'd4
  } access_t;

  // Region map keyed on the top address nibble; everything unclaimed falls to DRAM.
  function automatic access_t ACCESS_TYPE(input logic [XLEN-1:0] addr);
    access_t acc;
    case (addr[XLEN-1:XLEN-4])
      4'h8:    acc = ACC_BRAM;
      4'h9:    acc = ACC_IRAM;
      4'hE:    acc = ACC_GPIO;
      4'hF:    acc = ACC_UART;
      default: acc = ACC_DRAM;
    endcase
    return acc;
  endfunction
endpackage

module ladybird_bus_arbiter #(
  parameter int                     XLEN       = 32,
  parameter ladybird_pkg::core_bus_t FIRST_PRIO = ladybird_pkg::D_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_we,
  input  logic [XLEN/8-1:0] d_req_strb,
  input  logic [XLEN-1:0]   d_req_wdata,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_data,
  output logic              d_resp_err,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [XLEN-1:0]   i_req_addr,
  output logic              i_resp_valid,
  output logic [XLEN-1:0]   i_resp_data,
  output logic              i_resp_err,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [XLEN-1:0]   m_req_addr,
  output logic              m_req_we,
  output logic [XLEN/8-1:0] m_req_strb,
  output logic [XLEN-1:0]   m_req_wdata,
  output logic [2:0]        m_req_sel,
  output logic              m_req_src,
  input  logic              m_resp_valid,
  input  logic [XLEN-1:0]   m_resp_data
);
  import ladybird_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN/8-1:0] strb_q, strb_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  core_bus_t         src_q, src_d;
  core_bus_t         last_grant_q, last_grant_d;
  access_t           sel_q, sel_d;

  core_bus_t         winner;
  logic [XLEN-1:0]   win_addr;
  access_t           win_sel;
  logic              idle, accept, resp_pulse;

  always_comb begin
    if (d_req_valid && i_req_valid)
      winner = (last_grant_q == D_BUS) ? I_BUS : D_BUS;
    else if (i_req_valid)
      winner = I_BUS;
    else
      winner = D_BUS;
  end

  assign win_addr    = (winner == I_BUS) ? i_req_addr : d_req_addr;
  assign win_sel     = ACCESS_TYPE(win_addr);
  assign idle        = !rst && (state_q == S_IDLE);
  assign d_req_ready = idle && d_req_valid && (winner == D_BUS);
  assign i_req_ready = idle && i_req_valid && (winner == I_BUS);
  assign accept      = d_req_ready || i_req_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    strb_d       = strb_q;
    we_d         = we_q;
    err_d        = err_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d       = win_addr;
          sel_d        = win_sel;
          src_d        = winner;
          last_grant_d = winner;
          // Fetch is read-only: force a plain full-word read on the shared port.
          we_d         = (winner == I_BUS) ? 1'b0 : d_req_we;
          strb_d       = (winner == I_BUS) ? '1 : d_req_strb;
          wdata_d      = (winner == I_BUS) ? '0 : d_req_wdata;
          if (winner == I_BUS && (win_sel == ACC_UART || win_sel == ACC_GPIO)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: if (m_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (m_resp_valid) begin
          rdata_d = m_resp_data;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      strb_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      src_q        <= D_BUS;
      last_grant_q <= core_bus_t'(~FIRST_PRIO);
      sel_q        <= ACC_IRAM;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      strb_q       <= strb_d;
      we_q         <= we_d;
      err_q        <= err_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
    end
  end

  assign m_req_valid  = !rst && (state_q == S_ISSUE);
  assign m_req_addr   = addr_q;
  assign m_req_we     = we_q;
  assign m_req_strb   = strb_q;
  assign m_req_wdata  = wdata_q;
  assign m_req_sel    = sel_q;
  assign m_req_src    = src_q;

  // Response data and error are zeroed whenever the pulse is not on.
  assign resp_pulse   = !rst && (state_q == S_RESP);
  assign d_resp_valid = resp_pulse && (src_q == D_BUS);
  assign i_resp_valid = resp_pulse && (src_q == I_BUS);
  assign d_resp_data  = d_resp_valid ? rdata_q : '0;
  assign i_resp_data  = i_resp_valid ? rdata_q : '0;
  assign d_resp_err   = d_resp_valid && err_q;
  assign i_resp_err   = i_resp_valid && err_q;
endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: a table of single transactions plus
// hand-written round-robin, backpressure and mid-transaction reset sequences.
module tb_ladybird_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [3:0]  d_req_strb;
  logic        d_resp_valid, d_resp_err;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr, i_resp_data;
  logic        i_resp_valid, i_resp_err;
  logic        m_req_valid, m_req_ready, m_req_we, m_req_src;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
  logic [3:0]  m_req_strb;
  logic [2:0]  m_req_sel;
  logic        m_resp_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ladybird_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_strb(d_req_strb), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_strb(m_req_strb), .m_req_wdata(m_req_wdata),
    .m_req_sel(m_req_sel), .m_req_src(m_req_src),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
  );

  typedef struct {
    logic        is_i;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  exp_sel;
    logic        exp_err;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".d_rdy"},  32'(d_req_ready), 32'd0);
    chk({nm, ".i_rdy"},  32'(i_req_ready), 32'd0);
    chk({nm, ".m_vld"},  32'(m_req_valid), 32'd0);
    chk({nm, ".d_rvld"}, 32'(d_resp_valid), 32'd0);
    chk({nm, ".i_rvld"}, 32'(i_resp_valid), 32'd0);
    chk({nm, ".d_rerr"}, 32'(d_resp_err), 32'd0);
    chk({nm, ".i_rerr"}, 32'(i_resp_err), 32'd0);
    chk({nm, ".d_rdat"}, d_resp_data, 32'd0);
    chk({nm, ".i_rdat"}, i_resp_data, 32'd0);
    chk({nm, ".m_addr"}, m_req_addr, 32'd0);
    chk({nm, ".m_wdat"}, m_req_wdata, 32'd0);
    chk({nm, ".m_strb"}, 32'(m_req_strb), 32'd0);
    chk({nm, ".m_we"},   32'(m_req_we), 32'd0);
    chk({nm, ".m_sel"},  32'(m_req_sel), 32'd0);
    chk({nm, ".m_src"},  32'(m_req_src), 32'd0);
  endtask

  task automatic clear_inputs();
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_strb = '0; d_req_wdata = '0;
    i_req_valid = 1'b0; i_req_addr = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
  endtask

  // One isolated transaction; downstream accepts at once and answers the following cycle.
  task automatic run_vec(input vec_t v, input string nm);
    logic ov, xv, oe;
    logic [31:0] od;
    @(negedge clk);
    if (v.is_i) begin i_req_valid = 1'b1; i_req_addr = v.addr; end
    else        begin d_req_valid = 1'b1; d_req_addr = v.addr; end
    d_req_we = v.we; d_req_strb = v.strb; d_req_wdata = v.wdata;
    m_req_ready = 1'b1; m_resp_valid = 1'b0;
    #1;
    chk({nm, ".rdy"}, 32'(v.is_i ? i_req_ready : d_req_ready), 32'd1);
    chk({nm, ".no_mvld0"}, 32'(m_req_valid), 32'd0);
    @(negedge clk);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    #1;
    if (!v.exp_err) begin
      chk({nm, ".mvld"}, 32'(m_req_valid), 32'd1);
      chk({nm, ".addr"}, m_req_addr, v.addr);
      chk({nm, ".sel"},  32'(m_req_sel), 32'(v.exp_sel));
      chk({nm, ".src"},  32'(m_req_src), 32'(v.is_i));
      chk({nm, ".we"},   32'(m_req_we), 32'(v.exp_we));
      chk({nm, ".strb"}, 32'(m_req_strb), 32'(v.exp_strb));
      chk({nm, ".wdat"}, m_req_wdata, v.exp_wdata);
      @(negedge clk);
      m_resp_valid = 1'b1; m_resp_data = v.rdata;
      #1;
      chk({nm, ".early_rvld"}, 32'(d_resp_valid | i_resp_valid), 32'd0);
      @(negedge clk);
      m_resp_valid = 1'b0;
      #1;
    end else begin
      chk({nm, ".err_no_mvld"}, 32'(m_req_valid), 32'd0);
    end
    ov = v.is_i ? i_resp_valid : d_resp_valid;
    xv = v.is_i ? d_resp_valid : i_resp_valid;
    oe = v.is_i ? i_resp_err : d_resp_err;
    od = v.is_i ? i_resp_data : d_resp_data;
    chk({nm, ".rvld"},  32'(ov), 32'd1);
    chk({nm, ".other"}, 32'(xv), 32'd0);
    chk({nm, ".rerr"},  32'(oe), 32'(v.exp_err));
    chk({nm, ".rdat"},  od, v.exp_err ? 32'd0 : v.rdata);
    @(negedge clk);
    #1;
    chk({nm, ".rvld_off"}, 32'(d_resp_valid | i_resp_valid), 32'd0);
    chk({nm, ".rdat_off"}, d_resp_data | i_resp_data, 32'd0);
  endtask

  initial begin
    //           is_i  addr          we    strb   wdata         rdata         sel   err   ewe   estrb  ewdata
    vecs[0] = '{1'b0, 32'h8000_0010, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 3'd1, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'hF000_0000, 1'b1, 4'h1, 32'h41,       32'h0000_0001, 3'd3, 1'b0, 1'b1, 4'h1, 32'h41};
    vecs[2] = '{1'b1, 32'h9000_0000, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0000_0013, 3'd0, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 32'hE000_0004, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h1111_1111, 3'd4, 1'b1, 1'b0, 4'hF, 32'h0};
    vecs[4] = '{1'b1, 32'hF000_0008, 1'b0, 4'h3, 32'h1234_5678, 32'h2222_2222, 3'd3, 1'b1, 1'b0, 4'hF, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0,        32'hCAFE_F00D, 3'd2, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[6] = '{1'b0, 32'hE000_0000, 1'b1, 4'hF, 32'h0000_00FF, 32'h0,         3'd4, 1'b0, 1'b1, 4'hF, 32'h0000_00FF};
    vecs[7] = '{1'b0, 32'h9000_0040, 1'b1, 4'hC, 32'hAABB_0000, 32'h0,         3'd0, 1'b0, 1'b1, 4'hC, 32'hAABB_0000};

    // Reset: ready stays low even with a request pending, and every output comes up zero.
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h8000_0000; i_req_valid = 1'b1; i_req_addr = 32'h9000_0000;
    #1;
    chk("rst.d_rdy", 32'(d_req_ready), 32'd0);
    chk("rst.i_rdy", 32'(i_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk_idle_outputs("rst");

    for (int n = 0; n < 8; n++) run_vec(vecs[n], $sformatf("v%0d", n));

    // Round robin after reset: first tie goes to D_BUS, then alternates.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0100; d_req_we = 1'b0; d_req_strb = 4'hF;
    i_req_valid = 1'b1; i_req_addr = 32'h9000_0000;
    m_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_i;
      exp_i = k[0];
      #1;
      chk($sformatf("rr%0d.d_rdy", k), 32'(d_req_ready), 32'(!exp_i));
      chk($sformatf("rr%0d.i_rdy", k), 32'(i_req_ready), 32'(exp_i));
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.mvld", k), 32'(m_req_valid), 32'd1);
      chk($sformatf("rr%0d.src", k),  32'(m_req_src), 32'(exp_i));
      chk($sformatf("rr%0d.sel", k),  32'(m_req_sel), exp_i ? 32'd0 : 32'd2);
      chk($sformatf("rr%0d.addr", k), m_req_addr, exp_i ? 32'h9000_0000 : 32'h0000_0100);
      chk($sformatf("rr%0d.busy_rdy", k), 32'(d_req_ready | i_req_ready), 32'd0);
      @(negedge clk);
      m_resp_valid = 1'b1; m_resp_data = 32'h100 + 32'(k);
      @(negedge clk);
      m_resp_valid = 1'b0;
      #1;
      chk($sformatf("rr%0d.d_rvld", k), 32'(d_resp_valid), 32'(!exp_i));
      chk($sformatf("rr%0d.i_rvld", k), 32'(i_resp_valid), 32'(exp_i));
      chk($sformatf("rr%0d.rdat", k), exp_i ? i_resp_data : d_resp_data, 32'h100 + 32'(k));
      @(negedge clk);
    end

    // Backpressure: last grant was I_BUS, so D_BUS wins; the request must hold for 5 stalled cycles.
    d_req_addr = 32'h8000_0020; d_req_we = 1'b1; d_req_strb = 4'h3; d_req_wdata = 32'h5555;
    m_req_ready = 1'b0;
    #1;
    chk("bp.d_rdy", 32'(d_req_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d.mvld", c), 32'(m_req_valid), 32'd1);
      chk($sformatf("bp%0d.addr", c), m_req_addr, 32'h8000_0020);
      chk($sformatf("bp%0d.wdat", c), m_req_wdata, 32'h5555);
      chk($sformatf("bp%0d.strb", c), 32'(m_req_strb), 32'h3);
      chk($sformatf("bp%0d.we", c),   32'(m_req_we), 32'd1);
      chk($sformatf("bp%0d.rdy", c),  32'(d_req_ready | i_req_ready), 32'd0);
    end
    @(negedge clk);
    m_req_ready = 1'b1;
    #1;
    chk("bp.mvld_release", 32'(m_req_valid), 32'd1);
    @(negedge clk);
    d_req_valid = 1'b0; i_req_valid = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h77;
    #1;
    chk("bp.mvld_drop", 32'(m_req_valid), 32'd0);
    @(negedge clk);
    m_resp_valid = 1'b0;
    #1;
    chk("bp.d_rvld", 32'(d_resp_valid), 32'd1);
    chk("bp.rdat", d_resp_data, 32'h77);

    // Reset while waiting for the response; a stale response afterwards must be ignored.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0200; d_req_we = 1'b0; d_req_strb = 4'hF;
    #1;
    chk("mr.d_rdy", 32'(d_req_ready), 32'd1);
    @(negedge clk);
    d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'hBAD0_BAD0;
    #1;
    chk_idle_outputs("mr");
    @(negedge clk);
    m_resp_valid = 1'b0;
    #1;
    chk("mr.stale_d", 32'(d_resp_valid), 32'd0);
    chk("mr.stale_i", 32'(i_resp_valid), 32'd0);
    chk("mr.stale_m", 32'(m_req_valid), 32'd0);
    run_vec(vecs[0], "mr.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
